// File: rtl/mealy_fsm_decoder.sv
// Receive side of the 4-state Mealy line code: tracks encoder state, recovers x, deserialises MSB-first.
// Optional trailing even-parity symbol per word when DEC_PARITY_EN is defined.
module mealy_fsm_decoder #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             sync,
   input  logic             in_valid,
   input  logic             in_bit,
   output logic             in_ready,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_perr,
   output logic [1:0]       cur_state
);

`ifdef DEC_PARITY_EN
   localparam int LAST = WIDTH;
`else
   localparam int LAST = WIDTH - 1;
`endif
   localparam int CW = $clog2(LAST + 1);
   localparam logic [CW-1:0] LAST_C = CW'(LAST);

   typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} state_e;

   state_e           st_q, st_d, st_base, st_nxt;
   logic [CW-1:0]    cnt_q, cnt_d, cnt_base;
   logic [WIDTH-1:0] sh_q, sh_d, sh_base, shifted, word;
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] out_data_q, out_data_d;
   logic             perr_d, perr_q;
   logic             x, accept, last;

   always_comb begin
      // sync realigns before the symbol of the same cycle is decoded
      st_base  = sync ? S0 : st_q;
      cnt_base = sync ? '0 : cnt_q;
      sh_base  = sync ? '0 : sh_q;

      x        = in_bit ^ ((st_base == S0) || (st_base == S3));
      in_ready = !out_valid_q || out_ready || (cnt_q != LAST_C);
      accept   = in_valid && in_ready;
      last     = (cnt_base == LAST_C);
      shifted  = WIDTH'({sh_base, x});

      case (st_base)
         S0:      st_nxt = x ? S1 : S2;
         S1:      st_nxt = x ? S3 : S2;
         S2:      st_nxt = x ? S3 : S1;
         default: st_nxt = x ? S2 : S0;
      endcase

`ifdef DEC_PARITY_EN
      word   = sh_base;
      perr_d = perr_q;
`else
      word   = shifted;
      perr_d = 1'b0;
`endif

      st_d        = st_base;
      cnt_d       = cnt_base;
      sh_d        = sh_base;
      out_valid_d = out_valid_q && !out_ready;
      out_data_d  = out_data_q;

      if (accept) begin
         st_d = st_nxt;
         if (last) begin
            cnt_d       = '0;
            sh_d        = '0;
            out_valid_d = 1'b1;
            out_data_d  = word;
`ifdef DEC_PARITY_EN
            perr_d      = (^sh_base) ^ x;
`endif
         end else begin
            cnt_d = cnt_base + CW'(1);
            sh_d  = shifted;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st_q        <= S0;
         cnt_q       <= '0;
         sh_q        <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         perr_q      <= 1'b0;
      end else begin
         st_q        <= st_d;
         cnt_q       <= cnt_d;
         sh_q        <= sh_d;
         out_valid_q <= out_valid_d;
         out_data_q  <= out_data_d;
         perr_q      <= perr_d;
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_perr  = perr_q;
   assign cur_state = st_q;

endmodule
